// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch sequencer states
//   fetch_pkt_t   : instruction/PC pair handed to IF/ID
//   NOP, PC_INCR, ALIGN_MASK, align_pc()
package mips_fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // MIPS sll $0,$0,0
  localparam logic [XLEN-1:0] NOP        = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR    = 32'd4;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read handshake.
//   imem_req/imem_addr   : request from the fetch unit
//   imem_rdata/imem_ready: response from memory (rdata valid only with ready)
// Modports: master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if;
  import mips_fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// Single-entry instruction/PC holding register between memory and IF/ID.
//   clk, reset   : clock, async active-low reset
//   load_i       : capture pkt_i (accepted memory response)
//   flush_i      : discard held entry (redirect), highest priority
//   drain_i      : downstream consumed the entry this edge
//   pkt_i        : incoming instruction/PC
//   pkt_o/valid_o: held instruction/PC and its valid flag
module fetch_hold_buf
  import mips_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       flush_i,
  input  logic       drain_i,
  input  fetch_pkt_t pkt_i,
  output fetch_pkt_t pkt_o,
  output logic       valid_o
);

  fetch_pkt_t pkt_q;
  logic       valid_q;

  // Instruction falls back to NOP whenever the entry is invalidated, so the
  // output never needs a mux behind the register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_q.instr <= NOP_INSTR;
      pkt_q.pc    <= RESET_PC;
      valid_q     <= 1'b0;
    end else if (flush_i) begin
      pkt_q.instr <= NOP_INSTR;
      valid_q     <= 1'b0;
    end else if (load_i) begin
      pkt_q       <= pkt_i;
      valid_q     <= 1'b1;
    end else if (drain_i) begin
      pkt_q.instr <= NOP_INSTR;
      valid_q     <= 1'b0;
    end
  end

  assign pkt_o   = pkt_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem handshake,
// applies redirects and holds one instruction while IF/ID stalls.
//   clk, reset        : clock, async active-low reset
//   stall_in          : downstream hold (0 = IF/ID samples this edge)
//   redirect_valid/_target : taken branch/jump, target low bits ignored
//   halt_in           : stop fetching until the next redirect
//   imem              : if_fetch_unit_if.master memory handshake
//   instruction_out, pc_out, fetch_valid : registered IF/ID payload
//   perf_fetched, perf_stall_cycles : counters, live only when
//                       IF_FETCH_PERF_CNT_EN is defined, else tied to 0
module if_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_in,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_target,
  input  logic                 halt_in,
  if_fetch_unit_if.master      imem,
  output logic [XLEN-1:0]      instruction_out,
  output logic [XLEN-1:0]      pc_out,
  output logic                 fetch_valid,
  output logic [XLEN-1:0]      perf_fetched,
  output logic [XLEN-1:0]      perf_stall_cycles
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            buf_valid;
  logic            capture_c;
  fetch_pkt_t      buf_pkt;
  fetch_pkt_t      cap_pkt;

  // Request is suppressed while a stalled entry is held or a redirect is
  // changing the address, so imem_addr stays stable across wait states.
  assign imem.imem_req  = (state_q == S_FETCH) && !(buf_valid && stall_in)
                          && !redirect_valid;
  assign imem.imem_addr = pc_q;
  assign capture_c      = imem.imem_req && imem.imem_ready;

  assign cap_pkt.instr = imem.imem_rdata;
  assign cap_pkt.pc    = pc_q;

  // Sequencer and fetch PC; redirect overrides everything except reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
    end else if (redirect_valid) begin
      state_q <= S_FETCH;
      pc_q    <= align_pc(redirect_target);
    end else begin
      if (capture_c) begin
        pc_q <= XLEN'(pc_q + PC_INCR);
      end
      case (state_q)
        S_BOOT:  state_q <= S_FETCH;
        S_FETCH: if (halt_in) state_q <= S_HALT;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_BOOT;
      endcase
    end
  end

  fetch_hold_buf #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_hold_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (capture_c),
    .flush_i (redirect_valid),
    .drain_i (!stall_in),
    .pkt_i   (cap_pkt),
    .pkt_o   (buf_pkt),
    .valid_o (buf_valid)
  );

  assign instruction_out = buf_pkt.instr;
  assign pc_out          = buf_pkt.pc;
  assign fetch_valid     = buf_valid;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [XLEN-1:0] perf_fetched_q;
  logic [XLEN-1:0] perf_stall_q;

  // Free-running wrapping event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (capture_c) begin
        perf_fetched_q <= XLEN'(perf_fetched_q + XLEN'(1));
      end
      if (stall_in && buf_valid) begin
        perf_stall_q <= XLEN'(perf_stall_q + XLEN'(1));
      end
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  assign perf_fetched      = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule
